// File: rtl/diretorio_home.sv
// Home-node directory for an 8-block, 4-processor MSI-style coherence protocol.
// Optional invalidate counter (InvCount port) is built only when DIR_STATS_EN is defined.
module diretorio_home #(
    parameter int unsigned NPROC = 4,
    parameter int unsigned NBLK  = 8
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic [1:0]          ReqProc,
    input  logic [2:0]          ReqMsg,
    input  logic [2:0]          ReqBlock,
    output logic                MsgValid,
    input  logic                MsgReady,
    output logic [2:0]          MsgOut,
    output logic [1:0]          MsgDest,
    output logic [2:0]          MsgBlock,
    output logic [1:0]          EstadoDir
`ifdef DIR_STATS_EN
    ,
    output logic [7:0]          InvCount
`endif
);

    localparam int unsigned PW = 2;
    localparam int unsigned BW = 3;
    localparam int unsigned MW = 3;
    localparam int unsigned SW = 2;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SEND_INV   = 3'd1;
    localparam logic [2:0] S_SEND_FETCH = 3'd2;
    localparam logic [2:0] S_WAIT_WB    = 3'd3;
    localparam logic [2:0] S_SEND_REPLY = 3'd4;

    localparam logic [MW-1:0] M_WM    = 3'b001;
    localparam logic [MW-1:0] M_RM    = 3'b010;
    localparam logic [MW-1:0] M_INV   = 3'b011;
    localparam logic [MW-1:0] M_FETCH = 3'b100;
    localparam logic [MW-1:0] M_REPLY = 3'b101;
    localparam logic [MW-1:0] M_FINV  = 3'b110;
    localparam logic [MW-1:0] M_WB    = 3'b111;

    localparam logic [SW-1:0] D_U = 2'b00;
    localparam logic [SW-1:0] D_C = 2'b01;
    localparam logic [SW-1:0] D_M = 2'b10;

    // Lowest set bit index; also decodes the one-hot owner of a Modificado block.
    function automatic logic [PW-1:0] f_lowest(input logic [NPROC-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int i = int'(NPROC) - 1; i >= 0; i--) begin
            if (v[i]) r = PW'(i);
        end
        return r;
    endfunction

    logic [2:0]       r_state;
    logic             r_msg_valid;
    logic [MW-1:0]    r_msg_out;
    logic [PW-1:0]    r_msg_dest;
    logic [BW-1:0]    r_msg_blk;
    logic [SW-1:0]    r_estado;
    logic [SW-1:0]    r_dir_st [NBLK];
    logic [NPROC-1:0] r_dir_sh [NBLK];
    logic [PW-1:0]    r_proc;
    logic [BW-1:0]    r_blk;
    logic [PW-1:0]    r_owner;
    logic [NPROC-1:0] r_inv_rem;
    logic [SW-1:0]    r_upd_st;
    logic [NPROC-1:0] r_upd_sh;

    logic [2:0]       w_state_nxt;
    logic             w_mv_nxt;
    logic [MW-1:0]    w_mo_nxt;
    logic [PW-1:0]    w_md_nxt;
    logic [BW-1:0]    w_mb_nxt;
    logic [SW-1:0]    w_estado_nxt;
    logic [PW-1:0]    w_proc_nxt;
    logic [BW-1:0]    w_blk_nxt;
    logic [PW-1:0]    w_owner_nxt;
    logic [NPROC-1:0] w_inv_nxt;
    logic [SW-1:0]    w_upd_st_nxt;
    logic [NPROC-1:0] w_upd_sh_nxt;
    logic             w_dir_we;
    logic [BW-1:0]    w_dir_idx;
    logic [SW-1:0]    w_dir_st;
    logic [NPROC-1:0] w_dir_sh;

    logic [SW-1:0]    w_cur_st;
    logic [NPROC-1:0] w_cur_sh;
    logic [NPROC-1:0] w_pbit;
    logic [NPROC-1:0] w_others;
    logic [PW-1:0]    w_cur_owner;
    logic             w_req_hs;
    logic             w_msg_hs;
    logic             w_is_rd;

    assign w_cur_st    = r_dir_st[ReqBlock];
    assign w_cur_sh    = r_dir_sh[ReqBlock];
    assign w_pbit      = NPROC'(1) << ReqProc;
    assign w_others    = w_cur_sh & ~w_pbit;
    assign w_cur_owner = f_lowest(w_cur_sh);
    assign w_is_rd     = (ReqMsg == M_RM);
    assign w_req_hs    = ReqValid && ReqReady;
    assign w_msg_hs    = r_msg_valid && MsgReady;

    // Only the owner's Write-Back for the pending block may enter while waiting.
    always_comb begin
        ReqReady = 1'b0;
        case (r_state)
            S_IDLE:    ReqReady = 1'b1;
            S_WAIT_WB: ReqReady = (ReqMsg == M_WB) && (ReqProc == r_owner) && (ReqBlock == r_blk);
            default:   ReqReady = 1'b0;
        endcase
    end

    // Next-state, next-message and directory-write decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_mv_nxt     = r_msg_valid;
        w_mo_nxt     = r_msg_out;
        w_md_nxt     = r_msg_dest;
        w_mb_nxt     = r_msg_blk;
        w_estado_nxt = r_estado;
        w_proc_nxt   = r_proc;
        w_blk_nxt    = r_blk;
        w_owner_nxt  = r_owner;
        w_inv_nxt    = r_inv_rem;
        w_upd_st_nxt = r_upd_st;
        w_upd_sh_nxt = r_upd_sh;
        w_dir_we     = 1'b0;
        w_dir_idx    = r_blk;
        w_dir_st     = r_upd_st;
        w_dir_sh     = r_upd_sh;

        case (r_state)
            S_IDLE: begin
                if (w_req_hs && ReqMsg == M_WB) begin
                    if (w_cur_st == D_M && w_cur_sh[ReqProc]) begin
                        w_dir_we     = 1'b1;
                        w_dir_idx    = ReqBlock;
                        w_dir_st     = D_U;
                        w_dir_sh     = '0;
                        w_estado_nxt = D_U;
                    end
                end else if (w_req_hs && (ReqMsg == M_RM || ReqMsg == M_WM)) begin
                    w_proc_nxt   = ReqProc;
                    w_blk_nxt    = ReqBlock;
                    w_owner_nxt  = w_cur_owner;
                    w_estado_nxt = w_cur_st;
                    w_upd_st_nxt = w_cur_st;
                    w_upd_sh_nxt = w_cur_sh;
                    w_mv_nxt     = 1'b1;
                    w_mo_nxt     = M_REPLY;
                    w_md_nxt     = ReqProc;
                    w_mb_nxt     = ReqBlock;
                    w_state_nxt  = S_SEND_REPLY;
                    case (w_cur_st)
                        D_C: begin
                            if (w_is_rd) begin
                                w_upd_sh_nxt = w_cur_sh | w_pbit;
                            end else begin
                                w_upd_st_nxt = D_M;
                                w_upd_sh_nxt = w_pbit;
                                if (w_others != '0) begin
                                    w_state_nxt = S_SEND_INV;
                                    w_mo_nxt    = M_INV;
                                    w_md_nxt    = f_lowest(w_others);
                                    w_inv_nxt   = w_others & (w_others - NPROC'(1));
                                end
                            end
                        end
                        D_M: begin
                            if (!w_cur_sh[ReqProc]) begin
                                w_state_nxt = S_SEND_FETCH;
                                w_md_nxt    = w_cur_owner;
                                if (w_is_rd) begin
                                    w_mo_nxt     = M_FETCH;
                                    w_upd_st_nxt = D_C;
                                    w_upd_sh_nxt = w_cur_sh | w_pbit;
                                end else begin
                                    w_mo_nxt     = M_FINV;
                                    w_upd_sh_nxt = w_pbit;
                                end
                            end
                        end
                        default: begin
                            w_upd_st_nxt = w_is_rd ? D_C : D_M;
                            w_upd_sh_nxt = w_pbit;
                        end
                    endcase
                end
            end
            S_SEND_INV: begin
                if (w_msg_hs) begin
                    if (r_inv_rem != '0) begin
                        w_md_nxt  = f_lowest(r_inv_rem);
                        w_inv_nxt = r_inv_rem & (r_inv_rem - NPROC'(1));
                    end else begin
                        w_mo_nxt    = M_REPLY;
                        w_md_nxt    = r_proc;
                        w_state_nxt = S_SEND_REPLY;
                    end
                end
            end
            S_SEND_FETCH: begin
                if (w_msg_hs) begin
                    w_mv_nxt    = 1'b0;
                    w_state_nxt = S_WAIT_WB;
                end
            end
            S_WAIT_WB: begin
                if (w_req_hs) begin
                    w_mv_nxt    = 1'b1;
                    w_mo_nxt    = M_REPLY;
                    w_md_nxt    = r_proc;
                    w_mb_nxt    = r_blk;
                    w_state_nxt = S_SEND_REPLY;
                end
            end
            S_SEND_REPLY: begin
                // Entry commits only here, so an abandoned transaction leaves no trace.
                if (w_msg_hs) begin
                    w_mv_nxt     = 1'b0;
                    w_state_nxt  = S_IDLE;
                    w_dir_we     = 1'b1;
                    w_estado_nxt = r_upd_st;
                end
            end
            default: begin
                w_mv_nxt    = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state     <= S_IDLE;
            r_msg_valid <= 1'b0;
            r_msg_out   <= '0;
            r_msg_dest  <= '0;
            r_msg_blk   <= '0;
            r_estado    <= D_U;
            r_proc      <= '0;
            r_blk       <= '0;
            r_owner     <= '0;
            r_inv_rem   <= '0;
            r_upd_st    <= D_U;
            r_upd_sh    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_msg_valid <= w_mv_nxt;
            r_msg_out   <= w_mo_nxt;
            r_msg_dest  <= w_md_nxt;
            r_msg_blk   <= w_mb_nxt;
            r_estado    <= w_estado_nxt;
            r_proc      <= w_proc_nxt;
            r_blk       <= w_blk_nxt;
            r_owner     <= w_owner_nxt;
            r_inv_rem   <= w_inv_nxt;
            r_upd_st    <= w_upd_st_nxt;
            r_upd_sh    <= w_upd_sh_nxt;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < int'(NBLK); i++) begin
                r_dir_st[i] <= D_U;
                r_dir_sh[i] <= '0;
            end
        end else if (w_dir_we) begin
            r_dir_st[w_dir_idx] <= w_dir_st;
            r_dir_sh[w_dir_idx] <= w_dir_sh;
        end
    end

    assign MsgValid  = r_msg_valid;
    assign MsgOut    = r_msg_out;
    assign MsgDest   = r_msg_dest;
    assign MsgBlock  = r_msg_blk;
    assign EstadoDir = r_estado;

`ifdef DIR_STATS_EN
    logic       w_inv_hs;
    logic [7:0] r_inv_cnt;

    assign w_inv_hs = w_msg_hs && (r_state == S_SEND_INV);

    // Saturating count of delivered Invalidates.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_inv_cnt <= '0;
        end else if (w_inv_hs && r_inv_cnt != 8'hFF) begin
            r_inv_cnt <= r_inv_cnt + 8'd1;
        end
    end

    assign InvCount = r_inv_cnt;
`endif

endmodule

// File: tb/tb_diretorio_home.sv
// Directed self-checking bench for diretorio_home (InvCount checked when DIR_STATS_EN is defined).
module tb_diretorio_home;

    localparam logic [2:0] M_WM    = 3'b001;
    localparam logic [2:0] M_RM    = 3'b010;
    localparam logic [2:0] M_INV   = 3'b011;
    localparam logic [2:0] M_FETCH = 3'b100;
    localparam logic [2:0] M_REPLY = 3'b101;
    localparam logic [2:0] M_FINV  = 3'b110;
    localparam logic [2:0] M_WB    = 3'b111;

    logic       Clock;
    logic       Resetn;
    logic       ReqValid;
    logic       ReqReady;
    logic [1:0] ReqProc;
    logic [2:0] ReqMsg;
    logic [2:0] ReqBlock;
    logic       MsgValid;
    logic       MsgReady;
    logic [2:0] MsgOut;
    logic [1:0] MsgDest;
    logic [2:0] MsgBlock;
    logic [1:0] EstadoDir;
`ifdef DIR_STATS_EN
    logic [7:0] InvCount;
`endif

    int n_vec;
    int n_err;

    diretorio_home #(.NPROC(4), .NBLK(8)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqProc   (ReqProc),
        .ReqMsg    (ReqMsg),
        .ReqBlock  (ReqBlock),
        .MsgValid  (MsgValid),
        .MsgReady  (MsgReady),
        .MsgOut    (MsgOut),
        .MsgDest   (MsgDest),
        .MsgBlock  (MsgBlock),
        .EstadoDir (EstadoDir)
`ifdef DIR_STATS_EN
        ,
        .InvCount  (InvCount)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request from a negedge and hold it until accepted (bounded).
    task automatic do_req(input logic [1:0] p, input logic [2:0] m, input logic [2:0] b);
        int n;
        n = 0;
        ReqValid = 1'b1;
        ReqProc  = p;
        ReqMsg   = m;
        ReqBlock = b;
        #1;
        while (!ReqReady && n < 20) begin
            @(negedge Clock);
            #1;
            n++;
        end
        if (!ReqReady) check("req_accept_timeout", 0, 1);
        @(posedge Clock);
        @(negedge Clock);
        ReqValid = 1'b0;
    endtask

    // Check the pending message, then complete its handshake.
    task automatic expect_msg(input string tag, input logic [2:0] code, input logic [1:0] dest,
                              input logic [2:0] blk);
        check(tag, 32'({MsgValid, MsgOut, MsgDest, MsgBlock}), 32'({1'b1, code, dest, blk}));
        MsgReady = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        MsgReady = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        Resetn   = 1'b0;
        ReqValid = 1'b0;
        ReqProc  = '0;
        ReqMsg   = '0;
        ReqBlock = '0;
        MsgReady = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_msg", 32'({MsgValid, MsgOut, MsgDest, MsgBlock}), 0);
        check("rst_estado", 32'(EstadoDir), 0);
        check("rst_ready", 32'(ReqReady), 1);
        Resetn = 1'b1;
        @(negedge Clock);

        // Uncached read miss
        do_req(2'd1, M_RM, 3'd3);
        expect_msg("rm_uncached_reply", M_REPLY, 2'd1, 3'd3);
        check("rm_uncached_estado", 32'(EstadoDir), 1);
        check("rm_uncached_sh", 32'(dut.r_dir_sh[3]), 32'h2);
        check("reply_done_valid", 32'(MsgValid), 0);

        // Block 2 shared by P0, P1, P3, then P1 write miss
        do_req(2'd0, M_RM, 3'd2);
        expect_msg("sh_p0_reply", M_REPLY, 2'd0, 3'd2);
        do_req(2'd1, M_RM, 3'd2);
        expect_msg("sh_p1_reply", M_REPLY, 2'd1, 3'd2);
        do_req(2'd3, M_RM, 3'd2);
        expect_msg("sh_p3_reply", M_REPLY, 2'd3, 3'd2);
        check("sh_vector", 32'(dut.r_dir_sh[2]), 32'hB);
        do_req(2'd1, M_WM, 3'd2);
        check("inv_stall_ready", 32'(ReqReady), 0);
        expect_msg("inv_p0", M_INV, 2'd0, 3'd2);
        expect_msg("inv_p3", M_INV, 2'd3, 3'd2);
        expect_msg("wm_reply_p1", M_REPLY, 2'd1, 3'd2);
        check("wm_estado", 32'(EstadoDir), 2);
        check("wm_sh", 32'(dut.r_dir_sh[2]), 32'h2);
`ifdef DIR_STATS_EN
        check("inv_count", 32'(InvCount), 2);
`endif

        // Block 5 owned by P2, then P0 read miss with fetch
        do_req(2'd2, M_WM, 3'd5);
        expect_msg("own_p2_reply", M_REPLY, 2'd2, 3'd5);
        check("own_p2_estado", 32'(EstadoDir), 2);
        do_req(2'd0, M_RM, 3'd5);
        expect_msg("fetch_p2", M_FETCH, 2'd2, 3'd5);
        check("wait_wb_valid", 32'(MsgValid), 0);
        ReqValid = 1'b1;
        ReqProc  = 2'd3;
        ReqMsg   = M_RM;
        ReqBlock = 3'd5;
        #1;
        check("stall_p3_ready", 32'(ReqReady), 0);
        ReqProc  = 2'd2;
        ReqMsg   = M_WB;
        ReqBlock = 3'd4;
        #1;
        check("stall_wrong_blk", 32'(ReqReady), 0);
        @(negedge Clock);
        ReqValid = 1'b0;
        do_req(2'd2, M_WB, 3'd5);
        expect_msg("fetch_reply_p0", M_REPLY, 2'd0, 3'd5);
        check("fetch_sh", 32'(dut.r_dir_sh[5]), 32'h5);
        check("fetch_estado", 32'(EstadoDir), 1);

        // Reply held off for 4 cycles
        do_req(2'd3, M_RM, 3'd3);
        for (int i = 0; i < 4; i++) begin
            check("hold_stable", 32'({MsgValid, MsgOut, MsgDest, MsgBlock}),
                  32'({1'b1, M_REPLY, 2'd3, 3'd3}));
            @(negedge Clock);
        end
        expect_msg("hold_reply", M_REPLY, 2'd3, 3'd3);
        check("hold_one_xfer", 32'(MsgValid), 0);
        check("hold_sh", 32'(dut.r_dir_sh[3]), 32'hA);

        // Owner re-request and write-backs in IDLE
        do_req(2'd1, M_WM, 3'd2);
        expect_msg("owner_reply", M_REPLY, 2'd1, 3'd2);
        check("owner_sh", 32'(dut.r_dir_sh[2]), 32'h2);
        do_req(2'd0, M_WB, 3'd5);
        check("wb_nonowner_msg", 32'(MsgValid), 0);
        check("wb_nonowner_sh", 32'(dut.r_dir_sh[5]), 32'h5);
        do_req(2'd1, M_WB, 3'd2);
        check("wb_owner_msg", 32'(MsgValid), 0);
        check("wb_owner_estado", 32'(EstadoDir), 0);
        check("wb_owner_sh", 32'(dut.r_dir_sh[2]), 0);

        // Write miss from a non-owner of a Modificado block
        do_req(2'd0, M_WM, 3'd6);
        expect_msg("b6_p0_reply", M_REPLY, 2'd0, 3'd6);
        do_req(2'd3, M_WM, 3'd6);
        expect_msg("finv_p0", M_FINV, 2'd0, 3'd6);
        do_req(2'd0, M_WB, 3'd6);
        expect_msg("finv_reply_p3", M_REPLY, 2'd3, 3'd6);
        check("finv_sh", 32'(dut.r_dir_sh[6]), 32'h8);
        check("finv_estado", 32'(EstadoDir), 2);

        // Reset while waiting for a write-back
        do_req(2'd1, M_RM, 3'd6);
        expect_msg("pre_rst_fetch", M_FETCH, 2'd3, 3'd6);
        #2;
        Resetn = 1'b0;
        #1;
        check("rst_mid_valid", 32'(MsgValid), 0);
        check("rst_mid_b6", 32'({dut.r_dir_st[6], dut.r_dir_sh[6]}), 0);
        check("rst_mid_b5", 32'({dut.r_dir_st[5], dut.r_dir_sh[5]}), 0);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        do_req(2'd1, M_RM, 3'd6);
        expect_msg("post_rst_reply", M_REPLY, 2'd1, 3'd6);
        check("post_rst_estado", 32'(EstadoDir), 1);

        // Shared write miss with no other sharer goes straight to Reply
        do_req(2'd1, M_WM, 3'd6);
        expect_msg("solo_wm_reply", M_REPLY, 2'd1, 3'd6);
        check("solo_wm_estado", 32'(EstadoDir), 2);
`ifdef DIR_STATS_EN
        check("inv_count_rst", 32'(InvCount), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
